// File: rtl/cmt_trace_pkg.sv
// Shared types and widths for the commit trace FIFO.
// trace_rec_t is the unit stored in the FIFO and presented to the sink.
package cmt_trace_pkg;

  localparam int SEQW  = 64;
  localparam int GPRAW = 6;

  typedef struct packed {
    logic [SEQW-1:0]  seq;
    logic [63:0]      pc;
    logic [31:0]      ir;
    logic             gprw;
    logic [GPRAW-1:0] gpra;
    logic [63:0]      gprv;
  } trace_rec_t;

  // Width needed to hold a slot count of 0..pwd.
  function automatic int cnt_width(input int pwd);
    return $clog2(pwd + 1);
  endfunction

endpackage

// File: rtl/cmt_compact.sv
// Combinational prefix popcount over the commit mask: slot i lands at
// offset off[i] within this cycle's group; n is the group size.
module cmt_compact
  import cmt_trace_pkg::*;
#(
  parameter int pwd = 4
) (
  input  logic [pwd-1:0]                      cmt,
  output logic [pwd-1:0][cnt_width(pwd)-1:0]  off,
  output logic [pwd-1:0]                      en,
  output logic [cnt_width(pwd)-1:0]           n
);

  localparam int CW = cnt_width(pwd);

  logic [CW-1:0] acc;

  // NOTE: blocking '=' is intended here: acc is a running sum that each
  // loop iteration must see already updated by the previous slot.
  always_comb begin
    acc = '0;
    off = '0;
    for (int i = 0; i < pwd; i++) begin
      off[i] = acc;
      acc    = acc + CW'(cmt[i]);
    end
    n = acc;
  end

  assign en = cmt;

endmodule

// File: rtl/cmt_trace_fifo.sv
// Commit trace FIFO: compacts up to pwd commit slots per cycle, stamps
// sequence numbers, buffers them and streams one record per cycle.
module cmt_trace_fifo
  import cmt_trace_pkg::*;
#(
  parameter int pwd   = 4,
  parameter int depth = 16,
  parameter int hiwat = depth - pwd
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [pwd-1:0]                in_cmt,
  input  logic [pwd-1:0][63:0]          in_pc,
  input  logic [pwd-1:0][31:0]          in_ir,
  input  logic [pwd-1:0]                in_gprw,
  input  logic [pwd-1:0][GPRAW-1:0]     in_gpra,
  input  logic [pwd-1:0][63:0]          in_gprv,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SEQW-1:0]               out_seq,
  output logic [63:0]                   out_pc,
  output logic [31:0]                   out_ir,
  output logic                          out_gprw,
  output logic [GPRAW-1:0]              out_gpra,
  output logic [63:0]                   out_gprv,
  output logic                          almost_full,
  output logic [$clog2(depth):0]        level,
  output logic [63:0]                   drops,
  output logic                          ovf
);

  localparam int AW = $clog2(depth);
  localparam int LW = AW + 1;
  localparam int CW = cnt_width(pwd);

  trace_rec_t                 mem [depth];
  logic [AW-1:0]              head;
  logic [AW-1:0]              tail;
  logic [SEQW-1:0]            seq_ctr;

  logic [pwd-1:0][CW-1:0]     slot_off;
  logic [pwd-1:0]             slot_en;
  logic [CW-1:0]              grp_n;
  trace_rec_t                 slot_rec [pwd];

  logic [LW-1:0]              free;
  logic                       accept;
  logic                       pop;
  logic [LW-1:0]              level_nxt;
  trace_rec_t                 out_rec;

  cmt_compact #(.pwd(pwd)) u_compact (
    .cmt (in_cmt),
    .off (slot_off),
    .en  (slot_en),
    .n   (grp_n)
  );

  // Admission uses pre-pop occupancy so a same-cycle pop never makes room.
  assign free      = LW'(depth) - level;
  assign accept    = (LW'(grp_n) <= free);
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign level_nxt = level + (accept ? LW'(grp_n) : LW'(0)) - LW'(pop);

  always_comb begin
    for (int i = 0; i < pwd; i++) begin
      slot_rec[i] = '{seq:  seq_ctr + SEQW'(slot_off[i]),
                      pc:   in_pc[i],
                      ir:   in_ir[i],
                      gprw: in_gprw[i],
                      gpra: in_gpra[i],
                      gprv: in_gprv[i]};
    end
  end

  // NOTE: the storage array has no reset; every output field is gated by
  // level, so stale contents can never reach the sink.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < pwd; i++) begin
        if (slot_en[i]) mem[tail + AW'(slot_off[i])] <= slot_rec[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      level       <= '0;
      seq_ctr     <= '0;
      drops       <= '0;
      ovf         <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (accept) begin
        tail <= tail + AW'(grp_n);
      end else begin
        // Whole group dropped; its sequence numbers are still consumed.
        drops <= drops + 64'(grp_n);
        ovf   <= 1'b1;
      end
      if (pop) head <= head + AW'(1);
      level       <= level_nxt;
      seq_ctr     <= seq_ctr + SEQW'(grp_n);
      almost_full <= (level_nxt >= LW'(hiwat));
    end
  end

  assign out_rec  = out_valid ? mem[head] : '0;
  assign out_seq  = out_rec.seq;
  assign out_pc   = out_rec.pc;
  assign out_ir   = out_rec.ir;
  assign out_gprw = out_rec.gprw;
  assign out_gpra = out_rec.gpra;
  assign out_gprv = out_rec.gprv;

endmodule

// File: tb/tb_cmt_trace_fifo.sv
// Self-checking bench for cmt_trace_fifo: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_cmt_trace_fifo;
  import cmt_trace_pkg::*;

  localparam int PWD   = 4;
  localparam int DEPTH = 16;
  localparam int HIWAT = DEPTH - PWD;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [PWD-1:0]            in_cmt;
  logic [PWD-1:0][63:0]      in_pc;
  logic [PWD-1:0][31:0]      in_ir;
  logic [PWD-1:0]            in_gprw;
  logic [PWD-1:0][GPRAW-1:0] in_gpra;
  logic [PWD-1:0][63:0]      in_gprv;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEQW-1:0]           out_seq;
  logic [63:0]               out_pc;
  logic [31:0]               out_ir;
  logic                      out_gprw;
  logic [GPRAW-1:0]          out_gpra;
  logic [63:0]               out_gprv;
  logic                      almost_full;
  logic [$clog2(DEPTH):0]    level;
  logic [63:0]               drops;
  logic                      ovf;
  trace_rec_t                dut_rec;

  int checks = 0;
  int errors = 0;

  // Reference model: records in FIFO order, plus counters.
  trace_rec_t  q[$];
  logic [63:0] m_seq;
  logic [63:0] m_drops;
  logic        m_ovf;

  cmt_trace_fifo #(.pwd(PWD), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_cmt(in_cmt), .in_pc(in_pc), .in_ir(in_ir),
    .in_gprw(in_gprw), .in_gpra(in_gpra), .in_gprv(in_gprv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_seq(out_seq), .out_pc(out_pc), .out_ir(out_ir),
    .out_gprw(out_gprw), .out_gpra(out_gpra), .out_gprv(out_gprv),
    .almost_full(almost_full), .level(level), .drops(drops), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign dut_rec = '{seq: out_seq, pc: out_pc, ir: out_ir,
                     gprw: out_gprw, gpra: out_gpra, gprv: out_gprv};

  function automatic trace_rec_t exp_head();
    if (q.size() == 0) return '0;
    return q[0];
  endfunction

  task automatic set_idle();
    in_cmt  = '0;
    in_pc   = '0;
    in_ir   = '0;
    in_gprw = '0;
    in_gpra = '0;
    in_gprv = '0;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < PWD; i++) begin
      in_pc[i]   = {$urandom, $urandom};
      in_ir[i]   = $urandom;
      in_gprw[i] = 1'($urandom);
      in_gpra[i] = GPRAW'($urandom);
      in_gprv[i] = {$urandom, $urandom};
    end
  endtask

  // One clock edge; model is advanced from the inputs presented at the edge.
  task automatic tick();
    int n, k;
    bit pop;
    trace_rec_t r;
    @(posedge clk);
    n   = $countones(in_cmt);
    pop = (q.size() != 0) && out_ready;
    if (n <= DEPTH - q.size()) begin
      if (pop) void'(q.pop_front());
      k = 0;
      for (int i = 0; i < PWD; i++) begin
        if (in_cmt[i]) begin
          r.seq  = m_seq + 64'(k);
          r.pc   = in_pc[i];
          r.ir   = in_ir[i];
          r.gprw = in_gprw[i];
          r.gpra = in_gpra[i];
          r.gprv = in_gprv[i];
          q.push_back(r);
          k++;
        end
      end
    end else begin
      if (pop) void'(q.pop_front());
      m_drops = m_drops + 64'(n);
      m_ovf   = 1'b1;
    end
    m_seq = m_seq + 64'(n);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    out_ready = 1'b0;
    set_idle();
    q.delete();
    m_seq = '0;
    m_drops = '0;
    m_ovf = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (drops !== '0) begin errors++; $display("FAIL reset_drops got %0d exp 0", drops); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
    checks++; if (dut_rec !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", dut_rec); end
  endtask

  task automatic test_single();
    do_reset();
    rand_fields();
    in_cmt = 4'b0001;
    in_pc[0] = 64'h8000_0000;
    tick();
    set_idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_seq !== 64'd0) begin errors++; $display("FAIL single_seq got %0d exp 0", out_seq); end
    checks++; if (out_pc !== 64'h8000_0000) begin errors++; $display("FAIL single_pc got %h exp 80000000", out_pc); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
    checks++; if (dut_rec !== exp_head()) begin errors++; $display("FAIL single_rec got %h exp %h", dut_rec, exp_head()); end
  endtask

  task automatic test_sparse();
    do_reset();
    rand_fields();
    in_cmt = 4'b1010;
    in_pc[0] = 64'hdead; in_pc[1] = 64'h100;
    in_pc[2] = 64'hbeef; in_pc[3] = 64'h200;
    tick();
    set_idle();
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL sparse_level0 got %0d exp 2", level); end
    checks++; if (out_seq !== 64'd0 || out_pc !== 64'h100) begin errors++; $display("FAIL sparse_rec0 got seq %0d pc %h exp seq 0 pc 100", out_seq, out_pc); end
    out_ready = 1'b1;
    tick();
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL sparse_level1 got %0d exp 1", level); end
    checks++; if (out_seq !== 64'd1 || out_pc !== 64'h200) begin errors++; $display("FAIL sparse_rec1 got seq %0d pc %h exp seq 1 pc 200", out_seq, out_pc); end
    checks++; if (dut_rec !== exp_head()) begin errors++; $display("FAIL sparse_full1 got %h exp %h", dut_rec, exp_head()); end
    tick();
    checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL sparse_empty got level %0d valid %b exp 0 0", level, out_valid); end
    checks++; if (dut_rec !== '0) begin errors++; $display("FAIL sparse_zero got %h exp 0", dut_rec); end
    out_ready = 1'b0;
  endtask

  task automatic fill_full();
    for (int g = 0; g < 4; g++) begin
      rand_fields();
      in_cmt = 4'b1111;
      tick();
    end
    set_idle();
  endtask

  task automatic test_overflow();
    do_reset();
    fill_full();
    checks++; if (level !== 5'd16 || almost_full !== 1'b1) begin errors++; $display("FAIL ovf_full got level %0d af %b exp 16 1", level, almost_full); end
    rand_fields();
    in_cmt = 4'b0111;
    tick();
    set_idle();
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d exp 16", level); end
    checks++; if (drops !== 64'd3) begin errors++; $display("FAIL ovf_drops got %0d exp 3", drops); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (dut_rec !== exp_head()) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, dut_rec, exp_head()); end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", level); end
    rand_fields();
    in_cmt = 4'b0100;
    tick();
    set_idle();
    checks++; if (out_seq !== 64'd19) begin errors++; $display("FAIL ovf_gap_seq got %0d exp 19", out_seq); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
  endtask

  task automatic test_full_pop();
    do_reset();
    fill_full();
    out_ready = 1'b1;
    rand_fields();
    in_cmt = 4'b0001;
    tick();
    set_idle();
    out_ready = 1'b0;
    checks++; if (drops !== 64'd1) begin errors++; $display("FAIL fullpop_drops got %0d exp 1", drops); end
    checks++; if (level !== 5'd15) begin errors++; $display("FAIL fullpop_level got %0d exp 15", level); end
    checks++; if (out_seq !== 64'd1) begin errors++; $display("FAIL fullpop_seq got %0d exp 1", out_seq); end
  endtask

  task automatic test_wrap();
    int exp_seq, popped, max_lvl;
    do_reset();
    out_ready = 1'b1;
    exp_seq = 0; popped = 0; max_lvl = 0;
    for (int c = 0; c < 45; c++) begin
      if (out_valid && out_ready) begin
        checks++; if (out_seq !== 64'(exp_seq)) begin errors++; $display("FAIL wrap_seq got %0d exp %0d", out_seq, exp_seq); end
        checks++; if (dut_rec !== exp_head()) begin errors++; $display("FAIL wrap_rec got %h exp %h", dut_rec, exp_head()); end
        exp_seq++;
        popped++;
      end
      set_idle();
      if (c < 40) begin
        rand_fields();
        in_cmt = 4'b0001;
      end
      tick();
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    set_idle();
    out_ready = 1'b0;
    checks++; if (popped !== 40) begin errors++; $display("FAIL wrap_count got %0d exp 40", popped); end
    checks++; if (max_lvl > 1) begin errors++; $display("FAIL wrap_maxlevel got %0d exp <=1", max_lvl); end
    checks++; if (drops !== 64'd0) begin errors++; $display("FAIL wrap_drops got %0d exp 0", drops); end
  endtask

  task automatic test_async_reset();
    do_reset();
    fill_full();
    rand_fields();
    in_cmt = 4'b0111;
    tick();
    set_idle();
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    out_ready = 1'b0;
    checks++; if (level !== 5'd5 || ovf !== 1'b1) begin errors++; $display("FAIL areset_pre got level %0d ovf %b exp 5 1", level, ovf); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== '0) begin errors++; $display("FAIL areset_now got valid %b level %0d exp 0 0", out_valid, level); end
    checks++; if (drops !== '0 || ovf !== 1'b0) begin errors++; $display("FAIL areset_cnt got drops %0d ovf %b exp 0 0", drops, ovf); end
    checks++; if (dut_rec !== '0) begin errors++; $display("FAIL areset_data got %h exp 0", dut_rec); end
    do_reset();
    rand_fields();
    in_cmt = 4'b0010;
    tick();
    set_idle();
    checks++; if (out_valid !== 1'b1 || out_seq !== 64'd0) begin errors++; $display("FAIL areset_seq got valid %b seq %0d exp 1 0", out_valid, out_seq); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      in_cmt    = PWD'($urandom);
      out_ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, out_valid, q.size() != 0); end
      checks++; if (dut_rec !== exp_head()) begin errors++; $display("FAIL rnd_rec c%0d got %h exp %h", c, dut_rec, exp_head()); end
      checks++; if (int'(level) !== q.size()) begin errors++; $display("FAIL rnd_level c%0d got %0d exp %0d", c, level, q.size()); end
      checks++; if (drops !== m_drops || ovf !== m_ovf) begin errors++; $display("FAIL rnd_drops c%0d got %0d/%b exp %0d/%b", c, drops, ovf, m_drops, m_ovf); end
      checks++; if (almost_full !== (q.size() >= HIWAT)) begin errors++; $display("FAIL rnd_af c%0d got %b exp %b", c, almost_full, q.size() >= HIWAT); end
    end
    set_idle();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    set_idle();
    test_reset();
    test_single();
    test_sparse();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
